// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler: slot allocation, CDB operand wakeup and
// round-robin selection of one ready entry per cycle for ALU dispatch.
module rs_issue_scheduler #(
  parameter int RS_WIDTH      = 16,
  parameter int RS_IDX_BIT    = 4,
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     alloc_valid_in,
  input  logic                     alloc_qj_valid_in,
  input  logic [ROB_WIDTH_BIT-1:0] alloc_qj_in,
  input  logic                     alloc_qk_valid_in,
  input  logic [ROB_WIDTH_BIT-1:0] alloc_qk_in,
  output logic [RS_IDX_BIT-1:0]    alloc_idx_out,
  output logic                     full_out,
  input  logic                     cdb_valid_in,
  input  logic [ROB_WIDTH_BIT-1:0] cdb_tag_in,
  output logic                     issue_valid_out,
  output logic [RS_IDX_BIT-1:0]    issue_idx_out,
  input  logic                     issue_ready_in,
  output logic [RS_IDX_BIT:0]      count_out
);

  localparam int CW = RS_IDX_BIT + 1;

  logic [RS_WIDTH-1:0]      busy_q, busy_d, pend_j_q, pend_j_d, pend_k_q, pend_k_d, sel_q, sel_d;
  logic [ROB_WIDTH_BIT-1:0] tag_j_q [RS_WIDTH];
  logic [ROB_WIDTH_BIT-1:0] tag_j_d [RS_WIDTH];
  logic [ROB_WIDTH_BIT-1:0] tag_k_q [RS_WIDTH];
  logic [ROB_WIDTH_BIT-1:0] tag_k_d [RS_WIDTH];
  logic [RS_IDX_BIT-1:0]    rr_ptr_q, rr_ptr_d;
  logic                     issue_valid_q, issue_valid_d;
  logic [RS_IDX_BIT-1:0]    issue_idx_q, issue_idx_d;
  logic [CW-1:0]            count_q, count_d;

  logic [RS_WIDTH-1:0]      ready;
  logic [RS_IDX_BIT-1:0]    alloc_idx;
  logic [RS_IDX_BIT-1:0]    cand;
  logic [RS_IDX_BIT-1:0]    pick_idx;
  logic                     pick_found;
  logic                     do_alloc;
  logic                     hs;

  always_comb begin
    alloc_idx = '0;
    for (int i = RS_WIDTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = RS_IDX_BIT'(i);
    end
  end

  assign full_out        = &busy_q;
  assign alloc_idx_out   = alloc_idx;
  assign issue_valid_out = issue_valid_q;
  assign issue_idx_out   = issue_idx_q;
  assign count_out       = count_q;

  // Selection sees only registered state, so an entry written this edge waits a cycle.
  assign ready = busy_q & ~pend_j_q & ~pend_k_q & ~sel_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < RS_WIDTH; k++) begin
      cand = rr_ptr_q + RS_IDX_BIT'(k);
      if (!pick_found && ready[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign do_alloc = alloc_valid_in & ~full_out;
  assign hs       = issue_valid_q & issue_ready_in;

  always_comb begin
    busy_d        = busy_q;
    pend_j_d      = pend_j_q;
    pend_k_d      = pend_k_q;
    sel_d         = sel_q;
    tag_j_d       = tag_j_q;
    tag_k_d       = tag_k_q;
    rr_ptr_d      = rr_ptr_q;
    issue_valid_d = issue_valid_q;
    issue_idx_d   = issue_idx_q;
    count_d       = count_q;
    if (flush_in) begin
      busy_d        = '0;
      pend_j_d      = '0;
      pend_k_d      = '0;
      sel_d         = '0;
      rr_ptr_d      = '0;
      issue_valid_d = 1'b0;
      issue_idx_d   = '0;
      count_d       = '0;
    end else begin
      for (int i = 0; i < RS_WIDTH; i++) begin
        if (busy_q[i] && cdb_valid_in && tag_j_q[i] == cdb_tag_in) pend_j_d[i] = 1'b0;
        if (busy_q[i] && cdb_valid_in && tag_k_q[i] == cdb_tag_in) pend_k_d[i] = 1'b0;
      end
      if (hs) begin
        busy_d[issue_idx_q] = 1'b0;
        sel_d[issue_idx_q]  = 1'b0;
      end
      if (!issue_valid_q || hs) begin
        if (pick_found) begin
          sel_d[pick_idx] = 1'b1;
          issue_valid_d   = 1'b1;
          issue_idx_d     = pick_idx;
          rr_ptr_d        = pick_idx + RS_IDX_BIT'(1);
        end else begin
          issue_valid_d = 1'b0;
        end
      end
      // The free slot is never the one in dispatch, so alloc cannot collide with hs.
      if (do_alloc) begin
        busy_d[alloc_idx]   = 1'b1;
        sel_d[alloc_idx]    = 1'b0;
        pend_j_d[alloc_idx] = alloc_qj_valid_in & ~(cdb_valid_in & (cdb_tag_in == alloc_qj_in));
        pend_k_d[alloc_idx] = alloc_qk_valid_in & ~(cdb_valid_in & (cdb_tag_in == alloc_qk_in));
        tag_j_d[alloc_idx]  = alloc_qj_in;
        tag_k_d[alloc_idx]  = alloc_qk_in;
      end
      case ({do_alloc, hs})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy_q        <= '0;
      pend_j_q      <= '0;
      pend_k_q      <= '0;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      count_q       <= '0;
      for (int i = 0; i < RS_WIDTH; i++) begin
        tag_j_q[i] <= '0;
        tag_k_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q        <= busy_d;
      pend_j_q      <= pend_j_d;
      pend_k_q      <= pend_k_d;
      sel_q         <= sel_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      count_q       <= count_d;
      tag_j_q       <= tag_j_d;
      tag_k_q       <= tag_k_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: a vector table for single-slot flows
// plus hand sequences for full, round-robin order, backpressure, pause and flush.
module tb_rs_issue_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       rdy_in;
  logic       flush_in;
  logic       alloc_valid_in;
  logic       alloc_qj_valid_in;
  logic [3:0] alloc_qj_in;
  logic       alloc_qk_valid_in;
  logic [3:0] alloc_qk_in;
  logic [3:0] alloc_idx_out;
  logic       full_out;
  logic       cdb_valid_in;
  logic [3:0] cdb_tag_in;
  logic       issue_valid_out;
  logic [3:0] issue_idx_out;
  logic       issue_ready_in;
  logic [4:0] count_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       a;
    logic       jv;
    logic [3:0] j;
    logic       kv;
    logic [3:0] k;
    logic       cv;
    logic [3:0] c;
    logic       ir;
    logic       e_v;
    logic [3:0] e_idx;
    logic [4:0] e_cnt;
    logic [3:0] e_aidx;
    logic       e_full;
  } vec_t;

  vec_t vecs[$];

  rs_issue_scheduler #(.RS_WIDTH(16), .RS_IDX_BIT(4), .ROB_WIDTH_BIT(4)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .rdy_in           (rdy_in),
    .flush_in         (flush_in),
    .alloc_valid_in   (alloc_valid_in),
    .alloc_qj_valid_in(alloc_qj_valid_in),
    .alloc_qj_in      (alloc_qj_in),
    .alloc_qk_valid_in(alloc_qk_valid_in),
    .alloc_qk_in      (alloc_qk_in),
    .alloc_idx_out    (alloc_idx_out),
    .full_out         (full_out),
    .cdb_valid_in     (cdb_valid_in),
    .cdb_tag_in       (cdb_tag_in),
    .issue_valid_out  (issue_valid_out),
    .issue_idx_out    (issue_idx_out),
    .issue_ready_in   (issue_ready_in),
    .count_out        (count_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid_in    = 1'b0;
    alloc_qj_valid_in = 1'b0;
    alloc_qj_in       = '0;
    alloc_qk_valid_in = 1'b0;
    alloc_qk_in       = '0;
    cdb_valid_in      = 1'b0;
    cdb_tag_in        = '0;
  endtask

  task automatic alloc(input logic jv, input logic [3:0] j, input logic kv, input logic [3:0] k);
    alloc_valid_in    = 1'b1;
    alloc_qj_valid_in = jv;
    alloc_qj_in       = j;
    alloc_qk_valid_in = kv;
    alloc_qk_in       = k;
  endtask

  // Waits for each queued index to appear on a valid dispatch, issue_ready_in held high.
  task automatic drain(input string name);
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      if (issue_valid_out) check(name, issue_idx_out, exp_q.pop_front());
      step();
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // a jv j kv k cv c ir | valid idx count alloc_idx full
    vecs.push_back('{1,0,0,0,0,0,0,1, 0,0,1,1,0}); // ready alloc into slot 0
    vecs.push_back('{0,0,0,0,0,0,0,1, 1,0,1,1,0}); // selected one edge later
    vecs.push_back('{0,0,0,0,0,0,0,1, 0,0,0,0,0}); // dispatched, slot freed
    vecs.push_back('{1,1,5,0,0,0,0,1, 0,0,1,1,0}); // qj=5 pending
    vecs.push_back('{0,0,0,0,0,0,0,1, 0,0,1,1,0});
    vecs.push_back('{0,0,0,0,0,1,5,1, 0,0,1,1,0}); // CDB wakes it
    vecs.push_back('{0,0,0,0,0,0,0,1, 1,0,1,1,0});
    vecs.push_back('{0,0,0,0,0,0,0,1, 0,0,0,0,0});
    vecs.push_back('{1,1,5,0,0,1,5,1, 0,0,1,1,0}); // same-cycle bypass
    vecs.push_back('{0,0,0,0,0,0,0,1, 1,0,1,1,0});
    vecs.push_back('{0,0,0,0,0,0,0,1, 0,0,0,0,0});
    vecs.push_back('{1,1,3,1,7,1,5,1, 0,0,1,1,0}); // non-matching CDB
    vecs.push_back('{0,0,0,0,0,1,3,1, 0,0,1,1,0}); // j woken, k still pending
    vecs.push_back('{0,0,0,0,0,1,7,1, 0,0,1,1,0});
    vecs.push_back('{0,0,0,0,0,0,0,1, 1,0,1,1,0});
    vecs.push_back('{0,0,0,0,0,0,0,1, 0,0,0,0,0});
    vecs.push_back('{1,0,0,0,0,0,0,1, 0,0,1,1,0});
    vecs.push_back('{1,0,0,0,0,0,0,0, 1,0,2,2,0}); // alloc slot 1 while slot 0 selected
    vecs.push_back('{0,0,0,0,0,0,0,1, 1,1,1,0,0}); // alloc+dispatch pairs move to slot 1
    vecs.push_back('{0,0,0,0,0,0,0,1, 0,0,0,0,0});

    rst_n_in       = 1'b0;
    rdy_in         = 1'b1;
    flush_in       = 1'b0;
    issue_ready_in = 1'b0;
    idle_inputs();
    step();
    step();
    check("rst_valid", issue_valid_out, 0);
    check("rst_count", count_out, 0);
    rst_n_in = 1'b1;
    step();
    check("idle_valid", issue_valid_out, 0);
    check("idle_count", count_out, 0);
    check("idle_full", full_out, 0);
    check("idle_alloc_idx", alloc_idx_out, 0);

    foreach (vecs[i]) begin
      alloc_valid_in    = vecs[i].a;
      alloc_qj_valid_in = vecs[i].jv;
      alloc_qj_in       = vecs[i].j;
      alloc_qk_valid_in = vecs[i].kv;
      alloc_qk_in       = vecs[i].k;
      cdb_valid_in      = vecs[i].cv;
      cdb_tag_in        = vecs[i].c;
      issue_ready_in    = vecs[i].ir;
      step();
      check($sformatf("vec%0d_valid", i), issue_valid_out, vecs[i].e_v);
      if (vecs[i].e_v) check($sformatf("vec%0d_idx", i), issue_idx_out, vecs[i].e_idx);
      check($sformatf("vec%0d_count", i), count_out, vecs[i].e_cnt);
      check($sformatf("vec%0d_alloc_idx", i), alloc_idx_out, vecs[i].e_aidx);
      check($sformatf("vec%0d_full", i), full_out, vecs[i].e_full);
    end
    idle_inputs();

    // Fill every slot with a pending operand, then try one more.
    issue_ready_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill%0d_alloc_idx", i), alloc_idx_out, i);
      alloc(1'b0, 4'd0, 1'b1, 4'd9);
      step();
    end
    check("full_flag", full_out, 1);
    check("full_count", count_out, 16);
    step();
    check("full_ignored_count", count_out, 16);
    check("full_no_issue", issue_valid_out, 0);
    idle_inputs();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check("flush_count", count_out, 0);
    check("flush_full", full_out, 0);
    check("flush_alloc_idx", alloc_idx_out, 0);

    // Backpressure: slot 0 held while slots 1 and 2 queue up behind it.
    issue_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alloc(1'b0, 4'd0, 1'b0, 4'd0);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold%0d_valid", i), issue_valid_out, 1);
      check($sformatf("hold%0d_idx", i), issue_idx_out, 0);
    end
    issue_ready_in = 1'b1;
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    drain("order_012");
    check("after_012_valid", issue_valid_out, 0);
    check("after_012_count", count_out, 0);

    // Pointer now at 3: four entries woken together must leave 3, 0, 1, 2.
    for (int i = 0; i < 4; i++) begin
      alloc(1'b1, 4'd6, 1'b0, 4'd0);
      step();
    end
    idle_inputs();
    check("wait4_valid", issue_valid_out, 0);
    cdb_valid_in = 1'b1;
    cdb_tag_in   = 4'd6;
    step();
    idle_inputs();
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    drain("order_rr");
    check("after_rr_count", count_out, 0);

    // Pause freezes a pending dispatch and an alloc.
    alloc(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    idle_inputs();
    step();
    check("pre_pause_valid", issue_valid_out, 1);
    check("pre_pause_idx", issue_idx_out, 0);
    rdy_in = 1'b0;
    alloc(1'b0, 4'd0, 1'b0, 4'd0);
    cdb_valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("pause%0d_valid", i), issue_valid_out, 1);
      check($sformatf("pause%0d_idx", i), issue_idx_out, 0);
      check($sformatf("pause%0d_count", i), count_out, 1);
      check($sformatf("pause%0d_alloc_idx", i), alloc_idx_out, 1);
    end
    rdy_in   = 1'b1;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    idle_inputs();
    check("flush2_valid", issue_valid_out, 0);
    check("flush2_count", count_out, 0);
    check("flush2_full", full_out, 0);
    check("flush2_alloc_idx", alloc_idx_out, 0);

    // Earliest-issue latency after a flush.
    alloc(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    idle_inputs();
    check("lat_e0_valid", issue_valid_out, 0);
    step();
    check("lat_e1_valid", issue_valid_out, 1);
    check("lat_e1_idx", issue_idx_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
